// File: rtl/sysmem_pkg.sv
// Shared types and constants for the system-memory bus controller.
package sysmem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_CAPTURE,
    S_RESP
  } sysmem_state_e;

  localparam int SYSMEM_LANES      = 4;
  localparam int SYSMEM_LANE_W     = 8;
  localparam int SYSMEM_ADDR_WIDTH = 10;

endpackage

// File: rtl/sysmem_ctrl.sv
// picorv32 native-bus controller for four byte-lane BRAMs: window decode,
// read-latency sequencing with optional wait states, sticky out-of-window flag.
module sysmem_ctrl
  import sysmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ADDR_WIDTH  = SYSMEM_ADDR_WIDTH,
  parameter int          WAIT_STATES = 0
) (
  input  logic                                    clk,
  input  logic                                    resetn,
  input  logic                                    mem_valid,
  output logic                                    mem_ready,
  input  logic [31:0]                             mem_addr,
  input  logic [31:0]                             mem_wdata,
  input  logic [3:0]                              mem_wstrb,
  output logic [31:0]                             mem_rdata,
  input  logic                                    err_clr,
  output logic                                    bus_err,
  output logic [ADDR_WIDTH-1:0]                   ram_addr,
  output logic [SYSMEM_LANES-1:0]                 ram_ce,
  output logic [SYSMEM_LANES-1:0]                 ram_we,
  output logic [SYSMEM_LANES*SYSMEM_LANE_W-1:0]   ram_din,
  input  logic [SYSMEM_LANES*SYSMEM_LANE_W-1:0]   ram_dout,
  output logic                                    ram_rst
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  sysmem_state_e                           state_q, state_d;
  logic [3:0]                              wcnt_q, wcnt_d;
  logic                                    ready_q, ready_d;
  logic [31:0]                             rdata_q, rdata_d;
  logic                                    err_q, err_d;
  logic [ADDR_WIDTH-1:0]                   addr_q, addr_d;
  logic [SYSMEM_LANES-1:0]                 ce_q, ce_d, we_q, we_d;
  logic [SYSMEM_LANES*SYSMEM_LANE_W-1:0]   din_q, din_d;
  logic                                    in_win;
  logic                                    unused_byte_offset;

  // Byte offset is irrelevant: the bus always moves whole words.
  assign unused_byte_offset = ^mem_addr[1:0];
  assign in_win = (mem_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    ready_d = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q & ~err_clr;
    addr_d  = addr_q;
    din_d   = din_q;
    ce_d    = '0;
    we_d    = '0;
    // Enables are registered, so they are loaded on the edge that enters ACCESS.
    case (state_q)
      S_IDLE: begin
        if (mem_valid && !ready_q) begin
          if (in_win) begin
            addr_d  = mem_addr[ADDR_WIDTH+1:2];
            din_d   = mem_wdata;
            ce_d    = (mem_wstrb != 4'd0) ? mem_wstrb : 4'hF;
            we_d    = mem_wstrb;
            state_d = S_ACCESS;
          end else begin
            err_d   = 1'b1;
            rdata_d = '0;
            ready_d = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_ACCESS: begin
        if (we_q != '0) begin
          ready_d = 1'b1;
          state_d = S_RESP;
        end else if (WAIT_STATES > 0) begin
          wcnt_d  = WAIT_LOAD;
          state_d = S_WAIT;
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_WAIT: begin
        if (wcnt_q == 4'd0) state_d = S_CAPTURE;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      S_CAPTURE: begin
        rdata_d = ram_dout;
        ready_d = 1'b1;
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      ce_q    <= '0;
      we_q    <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      ce_q    <= ce_d;
      we_q    <= we_d;
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign bus_err   = err_q;
  assign ram_addr  = addr_q;
  assign ram_ce    = ce_q;
  assign ram_we    = we_q;
  assign ram_din   = din_q;
  assign ram_rst   = ~resetn;

endmodule

// File: tb/tb_sysmem_ctrl.sv
// Scoreboard bench: three controllers (0, 3 and 2 wait states) each with a
// byte-lane BRAM model; expected accesses/responses are queued at issue time.
module tb_sysmem_ctrl;

  typedef struct {
    int          g;
    int          cyc;
    logic [31:0] rdata;
    bit          chk;
  } resp_t;

  typedef struct {
    int          g;
    int          cyc;
    logic [9:0]  addr;
    logic [3:0]  ce;
    logic [3:0]  we;
    logic [31:0] din;
  } acc_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic        eclr;
  logic        rstn [3];
  logic        mv   [3];
  logic [31:0] ma   [3];
  logic [31:0] wdat [3];
  logic [3:0]  wstb [3];
  logic [2:0]  rdy_v;
  logic [2:0]  err_v;
  logic [2:0]  any_nz;
  resp_t       rq[$];
  acc_t        aq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h, required %h", nm, cyc, act, exp);
    end
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
    logic        ready, err, rst;
    logic [31:0] rdata, din, dout;
    logic [9:0]  addr;
    logic [3:0]  ce, we;
    logic [7:0]  mem [4][1024];

    sysmem_ctrl #(.BASE_ADDR(32'h0), .ADDR_WIDTH(10), .WAIT_STATES(WS)) u_dut (
      .clk(clk), .resetn(rstn[g]), .mem_valid(mv[g]), .mem_ready(ready),
      .mem_addr(ma[g]), .mem_wdata(wdat[g]), .mem_wstrb(wstb[g]), .mem_rdata(rdata),
      .err_clr(eclr), .bus_err(err), .ram_addr(addr), .ram_ce(ce), .ram_we(we),
      .ram_din(din), .ram_dout(dout), .ram_rst(rst)
    );

    assign rdy_v[g]  = ready;
    assign err_v[g]  = err;
    assign any_nz[g] = ready | err | (|rdata) | (|addr) | (|ce) | (|we) | (|din);

    // Read-first byte-lane BRAM model.
    always @(posedge clk) begin
      for (int l = 0; l < 4; l++) begin
        if (ce[l]) begin
          if (we[l]) mem[l][addr] <= din[8*l +: 8];
          dout[8*l +: 8] <= mem[l][addr];
        end
      end
    end

    always @(negedge clk) begin
      resp_t r;
      acc_t  a;
      if (rstn[g]) check($sformatf("ram_rst_dut%0d", g), {31'd0, rst}, 32'd0);
      if (ready === 1'b1) begin
        if (rq.size() == 0) begin
          check($sformatf("resp_unexpected_dut%0d", g), 32'd1, 32'd0);
        end else begin
          r = rq.pop_front();
          check("resp_dut", g, r.g);
          check($sformatf("resp_cycle_dut%0d", g), cyc, r.cyc);
          if (r.chk) check($sformatf("resp_rdata_dut%0d", g), rdata, r.rdata);
        end
      end
      if ((ce !== 4'd0) || (we !== 4'd0)) begin
        if (aq.size() == 0) begin
          check($sformatf("ram_ce_unexpected_dut%0d", g), {24'd0, we, ce}, 32'd0);
        end else begin
          a = aq.pop_front();
          check("acc_dut", g, a.g);
          check($sformatf("acc_cycle_dut%0d", g), cyc, a.cyc);
          check($sformatf("acc_addr_dut%0d", g), {22'd0, addr}, {22'd0, a.addr});
          check($sformatf("acc_ce_dut%0d", g), {28'd0, ce}, {28'd0, a.ce});
          check($sformatf("acc_we_dut%0d", g), {28'd0, we}, {28'd0, a.we});
          check($sformatf("acc_din_dut%0d", g), din, a.din);
        end
      end
    end
  end

  // lat = 0 means no response is expected; acc = 0 means no BRAM access is expected.
  task automatic start(input int g, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                       input logic [31:0] exp_rd, input bit chk, input int lat, input bit acc);
    acc_t  ae;
    resp_t re;
    mv[g] = 1'b1; ma[g] = a; wdat[g] = wd; wstb[g] = st;
    if (acc) begin
      ae.g = g; ae.cyc = cyc + 1; ae.addr = a[11:2];
      ae.ce = (st == 4'd0) ? 4'hF : st; ae.we = st; ae.din = wd;
      aq.push_back(ae);
    end
    if (lat > 0) begin
      re.g = g; re.cyc = cyc + lat; re.rdata = exp_rd; re.chk = chk;
      rq.push_back(re);
    end
  endtask

  task automatic wait_done(input int g);
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      eclr = 1'b0;
      if (rdy_v[g]) done = 1;
    end
    mv[g] = 1'b0;
    if (!done) check($sformatf("ready_timeout_dut%0d", g), 32'd0, 32'd1);
  endtask

  task automatic xfer(input int g, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                      input logic [31:0] exp_rd, input int lat, input bit acc);
    @(posedge clk); #1;
    start(g, a, wd, st, exp_rd, 1'b1, lat, acc);
    wait_done(g);
  endtask

  initial begin
    eclr = 1'b0;
    for (int g = 0; g < 3; g++) begin
      rstn[g] = 1'b0; mv[g] = 1'b0; ma[g] = '0; wdat[g] = '0; wstb[g] = '0;
    end
    // Request held during reset must not be accepted until release.
    mv[0] = 1'b1; ma[0] = 32'h10; wdat[0] = 32'hDEADBEEF; wstb[0] = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {29'd0, any_nz}, 32'd0);
    for (int g = 0; g < 3; g++) rstn[g] = 1'b1;
    start(0, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b1, 2, 1'b1);
    wait_done(0);

    xfer(1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2, 1'b1);
    xfer(2, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2, 1'b1);
    xfer(0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 3, 1'b1);
    xfer(1, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 6, 1'b1);
    xfer(0, 32'h10, 32'h12000000, 4'h8, 32'hDEADBEEF, 2, 1'b1);
    xfer(0, 32'h13, 32'h0, 4'h0, 32'h12ADBEEF, 3, 1'b1);
    xfer(2, 32'h10, 32'h12000000, 4'h8, 32'h0, 2, 1'b1);

    // Out-of-window access: no lane enables, zero data, sticky error.
    xfer(0, 32'h1000, 32'h0, 4'h0, 32'h0, 1, 1'b0);
    check("bus_err_set", {31'd0, err_v[0]}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("bus_err_hold", {31'd0, err_v[0]}, 32'd1);
    @(posedge clk); #1;
    start(0, 32'h2000, 32'h0, 4'h0, 32'h0, 1'b1, 1, 1'b0);
    eclr = 1'b1;
    wait_done(0);
    check("bus_err_set_wins", {31'd0, err_v[0]}, 32'd1);
    @(posedge clk); #1;
    eclr = 1'b1;
    @(posedge clk); #1;
    eclr = 1'b0;
    check("bus_err_cleared", {31'd0, err_v[0]}, 32'd0);
    xfer(0, 32'h10, 32'h0, 4'h0, 32'h12ADBEEF, 3, 1'b1);
    check("bus_err_stays_clear", {31'd0, err_v[0]}, 32'd0);

    // Reset asserted while the 2-wait-state controller is in WAIT.
    @(posedge clk); #1;
    start(2, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0, 0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn[2] = 1'b0; mv[2] = 1'b0;
    @(posedge clk); #1;
    check("reset_mid_wait_outputs", {31'd0, any_nz[2]}, 32'd0);
    rstn[2] = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("no_ready_after_reset", {31'd0, rdy_v[2]}, 32'd0);
    xfer(2, 32'h10, 32'h0, 4'h0, 32'h12ADBEEF, 5, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("resp_queue_drained", rq.size(), 32'd0);
    check("acc_queue_drained", aq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sysmem_ctrl.md
# sysmem_ctrl

Bus-side controller for the on-chip system memory. It accepts picorv32 native memory-interface transfers, decodes the address window, and drives four 1024×8 single-port BRAM byte lanes (lane 0 = bits 7:0 … lane 3 = bits 31:24). It sequences the one-cycle BRAM read latency and returns a registered `mem_ready` / `mem_rdata` response to the core. It also flags out-of-window accesses.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0000: window base; must be aligned to 4·2^ADDR_WIDTH bytes.
- `ADDR_WIDTH`, 10: word-address bits per lane (1024 words = 4 KiB).
- `WAIT_STATES`, 0: extra read cycles inserted after the BRAM sample (0–15).

Ports:
- `clk`  in  1  system clock.
- `resetn`  in  1  synchronous, active-low reset.
- `mem_valid`  in  1  core transfer request.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_addr`  in  32  byte address.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte strobes; 0 = read.
- `mem_rdata`  out  32  registered read data.
- `err_clr`  in  1  clears `bus_err`.
- `bus_err`  out  1  sticky out-of-window flag.
- `ram_addr`  out  ADDR_WIDTH  shared lane address.
- `ram_ce`  out  4  per-lane clock enable.
- `ram_we`  out  4  per-lane write enable.
- `ram_din`  out  32  lane write data, byte i to lane i.
- `ram_dout`  in  32  lane read data, valid the cycle after the sampling edge.
- `ram_rst`  out  1  lane output reset; equals `~resetn`.

## Operation
- States: IDLE, ACCESS, WAIT, CAPTURE, RESP.
- **IDLE:** a request is accepted when `mem_valid && !mem_ready`.
  - In-window test: `mem_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]`.
  - In window: register `ram_addr = mem_addr[ADDR_WIDTH+1:2]` and `ram_din = mem_wdata`, then go to ACCESS.
  - Out of window: set `bus_err`, load `mem_rdata = 0`, go to RESP. No `ram_ce` is asserted.
  - `mem_addr[1:0]` is ignored.
- **ACCESS** (exactly one cycle):
  - Read: `ram_ce = 4'hF`, `ram_we = 0`.
  - Write: `ram_ce = ram_we = mem_wstrb`; a strobe of 0 on a lane leaves that lane untouched.
  - Next state: a write goes to RESP. A read goes to WAIT if WAIT_STATES > 0, else to CAPTURE.
- **WAIT:** the counter loads WAIT_STATES−1 on entry and decrements each cycle; at 0, go to CAPTURE. `ram_ce` and `ram_we` are 0.
- **CAPTURE:** `mem_rdata <= ram_dout`, then go to RESP.
- **RESP:** `mem_ready = 1` for exactly one cycle, then go to IDLE. `mem_rdata` holds its value until the next capture or reset.
- `ram_ce` and `ram_we` are 0 in every state except ACCESS.
- `bus_err`:
  - Set on an out-of-window accept.
  - Cleared by `err_clr`.
  - If a set and a clear occur in the same cycle, set wins.
- A `mem_valid` drop mid-transfer is a protocol violation; the transfer still completes with a RESP pulse.

## Timing
- Reset values (resetn low at an edge): state IDLE, `mem_ready` 0, `mem_rdata` 0, `bus_err` 0, `ram_ce` 0, `ram_we` 0, `ram_addr` 0, `ram_din` 0, wait counter 0.
- Reset mid-operation: the next state is IDLE, with no `mem_ready` pulse and no further BRAM enables.
- Latency, counting cycle 0 as the first cycle `mem_valid` is high in IDLE:
  - In-window write: `mem_ready` high in cycle 2.
  - In-window read: `mem_ready` high in cycle 3 + WAIT_STATES.
  - Out-of-window: `mem_ready` high in cycle 1.
- Back-to-back requests: the next request is accepted no earlier than the cycle after RESP, so throughput is one transfer per (latency + 1) cycles.
- All outputs are registered except `ram_rst`.

## Structure
- Package `sysmem_pkg` holds:
  - the state enum;
  - `SYSMEM_LANES = 4`;
  - the lane byte width `8`;
  - default `SYSMEM_ADDR_WIDTH = 10`.
- Single module; no sub-module is warranted. The four byte-lane BRAM instances belong to the parent `sysmem` top, not to this block.

## Test plan
- Reset: hold `resetn` low for 2 cycles with `mem_valid` = 1 -> every output is 0 and no `ram_ce` is seen; the accept happens only after release.
- Write: 0xDEADBEEF to 0x0000_0010, wstrb F -> during ACCESS `ram_addr` = 4, `ram_ce` = `ram_we` = F, `ram_din` = DEADBEEF; `mem_ready` high in cycle 2 only.
- Read of 0x10 with WAIT_STATES = 0 (lane model returns the stored data) -> `mem_rdata` = DEADBEEF with `mem_ready` in cycle 3; `ram_we` stays 0; repeat with WAIT_STATES = 3 -> `mem_ready` in cycle 6.
- Byte write: 0x12000000, wstrb 8, then read 0x10 -> only `ram_ce[3]` and `ram_we[3]` are set; the read returns 0x12ADBEEF.
- Out-of-window: read 0x0000_1000 -> no `ram_ce`; `mem_ready` in cycle 1; `mem_rdata` = 0; `bus_err` = 1, holding until `err_clr`; `err_clr` together with a new error leaves it at 1.
- Reset during WAIT (WAIT_STATES = 2) -> IDLE on the next cycle with no `mem_ready` pulse; a following read of 0x10 returns 0x12ADBEEF normally.
